mem_bank_array: RTL

- Parametrised, multi-bank, single-port synchronous memory block with valid/ready request and response handshakes and a registered response queue.
- Generalises the fixed 16-bit x 1024-word memory macro with chip_en/wr_en/rd_en controls.
- Adds configurable width, depth and bank count, plus per-lane write masking and response backpressure.
- Sits between a datapath requester and on-chip storage.

---
 rtl/mem_bank_array_pkg.sv | 24 ++
 rtl/mem_bank_array_if.sv | 34 +++
 rtl/mem_bank_array_core.sv | 73 +++++++
 rtl/mem_bank_array.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mem_bank_array_pkg.sv
// Shared types, build widths and helpers for mem_bank_array.
// Holds the default geometry, response entry type and lane parity function.
package mem_bank_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 10;
  localparam int NUM_BANKS  = 4;
  localparam int LANE_W     = 8;
  localparam int NUM_LANES  = DATA_W / LANE_W;
  localparam int BANK_SEL_W = $clog2(NUM_BANKS);
  localparam int BANK_DEPTH = (2 ** ADDR_W) / NUM_BANKS;
  localparam int BANK_AW    = ADDR_W - BANK_SEL_W;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_entry_t;

  // Even parity: the stored bit makes the lane plus parity have even weight.
  function automatic logic lane_parity(input logic [LANE_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_bank_array_if.sv
// Request/response bus between a requester (master) and mem_bank_array (slave).
// Carries chip_en, the req valid/ready handshake with command fields, and the rsp handshake with data/err.
interface mem_bank_array_if #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int NUM_LANES = 2
) ();

  logic                 chip_en;
  logic                 req_valid;
  logic                 req_ready;
  logic                 wr_en;
  logic                 rd_en;
  logic [ADDR_W-1:0]    addr;
  logic [DATA_W-1:0]    wr_data;
  logic [NUM_LANES-1:0] wr_mask;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_W-1:0]    rd_data;
  logic                 rsp_err;

  modport master (
    output chip_en, req_valid, wr_en, rd_en,
    output addr, wr_data, wr_mask, rsp_ready,
    input  req_ready, rsp_valid, rd_data, rsp_err
  );

  modport slave (
    input  chip_en, req_valid, wr_en, rd_en,
    input  addr, wr_data, wr_mask, rsp_ready,
    output req_ready, rsp_valid, rd_data, rsp_err
  );

endinterface

// File: rtl/mem_bank_array_core.sv
// mem_bank_core: one storage bank, synchronous read register, lane-masked write.
// Ports: clk_i, en_i, we_i, re_i, addr_i, wdata_i, mask_i -> rdata_o, rerr_o. Parity bits under MEM_BANK_PARITY_EN.
module mem_bank_core
  import mem_bank_pkg::*;
#(
  parameter int DW = 16,
  parameter int LW = 8,
  parameter int AW = 8
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [DW-1:0]    wdata_i,
  input  logic [DW/LW-1:0] mask_i,
  output logic [DW-1:0]    rdata_o,
  output logic             rerr_o
);

  localparam int NL    = DW / LW;
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Read samples the old word, so read+write returns pre-write data.
  always_ff @(posedge clk_i) begin
    if (en_i && re_i) begin
      rdata_q <= mem_q[addr_i];
    end
    if (en_i && we_i) begin
      for (int l = 0; l < NL; l++) begin
        if (mask_i[l]) begin
          mem_q[addr_i][l*LW +: LW] <= wdata_i[l*LW +: LW];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

`ifdef MEM_BANK_PARITY_EN
  logic [NL-1:0] par_q [DEPTH];
  logic [NL-1:0] rpar_q;
  logic [NL-1:0] chk;

  always_ff @(posedge clk_i) begin
    if (en_i && re_i) begin
      rpar_q <= par_q[addr_i];
    end
    if (en_i && we_i) begin
      for (int l = 0; l < NL; l++) begin
        if (mask_i[l]) begin
          par_q[addr_i][l] <= lane_parity(wdata_i[l*LW +: LW]);
        end
      end
    end
  end

  always_comb begin
    chk = '0;
    for (int l = 0; l < NL; l++) begin
      chk[l] = lane_parity(rdata_q[l*LW +: LW]) ^ rpar_q[l];
    end
  end

  assign rerr_o = |chk;
`else
  assign rerr_o = 1'b0;
`endif

endmodule

// File: rtl/mem_bank_array.sv
// mem_bank_array: banked single-port memory with valid/ready request and 2-deep response queue.
// Ports: clock, reset (async, active-high), bus (mem_bank_array_if.slave). Parity via MEM_BANK_PARITY_EN.
module mem_bank_array
  import mem_bank_pkg::*;
#(
  parameter int DATA_W    = mem_bank_pkg::DATA_W,
  parameter int ADDR_W    = mem_bank_pkg::ADDR_W,
  parameter int NUM_BANKS = mem_bank_pkg::NUM_BANKS,
  parameter int LANE_W    = mem_bank_pkg::LANE_W
) (
  input  logic              clock,
  input  logic              reset,
  mem_bank_array_if.slave   bus
);

  localparam int NL  = DATA_W / LANE_W;
  localparam int BSW = $clog2(NUM_BANKS);
  localparam int BAW = ADDR_W - BSW;

  logic              accept;
  logic              acc_rd;
  logic [BSW-1:0]    sel;
  logic [BAW-1:0]    baddr;
  logic [NUM_BANKS-1:0] bank_en;
  logic [DATA_W-1:0] bank_rd  [NUM_BANKS];
  logic              bank_err [NUM_BANKS];

  logic              infl_q, infl_d;
  logic [BSW-1:0]    isel_q, isel_d;
  logic [1:0]        credits_q, credits_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;
  rsp_entry_t        q_q [2];
  rsp_entry_t        q_d [2];

  rsp_entry_t        infl_e;
  rsp_entry_t        head;
  logic              rsp_v;
  logic              pop;
  logic              byp_pop;
  logic              q_pop;
  logic              push;

  assign sel    = bus.addr[ADDR_W-1 -: BSW];
  assign baddr  = bus.addr[BAW-1:0];
  assign accept = bus.req_valid && bus.req_ready;
  assign acc_rd = accept && bus.rd_en;

  assign bus.req_ready = bus.chip_en && !reset && (credits_q < 2'd2);

  always_comb begin
    bank_en = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_en[b] = accept && (bus.wr_en || bus.rd_en) && (sel == BSW'(b));
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank_core #(
      .DW (DATA_W),
      .LW (LANE_W),
      .AW (BAW)
    ) u_bank (
      .clk_i   (clock),
      .en_i    (bank_en[b]),
      .we_i    (bus.wr_en),
      .re_i    (bus.rd_en),
      .addr_i  (baddr),
      .wdata_i (bus.wr_data),
      .mask_i  (bus.wr_mask[NL-1:0]),
      .rdata_o (bank_rd[b]),
      .rerr_o  (bank_err[b])
    );
  end

  // The in-flight read sits in its bank's read register for one cycle;
  // with the queue empty it is presented directly, giving latency 1.
  assign infl_e = '{data: bank_rd[isel_q], err: bank_err[isel_q]};
  assign rsp_v  = infl_q || (cnt_q != 2'd0);
  assign head   = (cnt_q == 2'd0 && infl_q) ? infl_e : q_q[rptr_q];
  assign pop    = rsp_v && bus.rsp_ready;

  assign bus.rsp_valid = rsp_v;
  assign bus.rd_data   = head.data;
  assign bus.rsp_err   = head.err;

  // An unconsumed in-flight word must move into the queue, since a later
  // read to the same bank overwrites the bank register. Credits guarantee room.
  always_comb begin
    q_d       = q_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    byp_pop   = pop && (cnt_q == 2'd0);
    q_pop     = pop && (cnt_q != 2'd0);
    push      = infl_q && !byp_pop;
    if (push) begin
      q_d[wptr_q] = infl_e;
      wptr_d      = ~wptr_q;
    end
    if (q_pop) begin
      rptr_d = ~rptr_q;
    end
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, q_pop};
    infl_d    = acc_rd;
    isel_d    = acc_rd ? sel : isel_q;
    credits_d = credits_q + {1'b0, acc_rd} - {1'b0, pop};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      infl_q    <= 1'b0;
      isel_q    <= '0;
      credits_q <= 2'd0;
      cnt_q     <= 2'd0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_q[i] <= '0;
      end
    end else begin
      infl_q    <= infl_d;
      isel_q    <= isel_d;
      credits_q <= credits_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      q_q       <= q_d;
    end
  end

endmodule
